// File: rtl/systolic_skew_feeder.sv
// Operand sequencer for an output-stationary systolic matmul array: captures A/B on start
// and streams diagonally skewed row/column operands, with stall, B-transpose and drain timing.
module systolic_skew_feeder #(
  parameter int W      = 16,
  parameter int ROWS   = 3,
  parameter int COLS   = 3,
  parameter int K      = 3,
  parameter int PE_LAT = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic                  i_mode,
  input  logic [W*ROWS*K-1:0]   i_A,
  input  logic [W*K*COLS-1:0]   i_B,
  input  logic                  i_stall,
  output logic [W*ROWS-1:0]     o_pe_a,
  output logic [W*COLS-1:0]     o_pe_b,
  output logic                  o_feed_valid,
  output logic                  o_acc_clr,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam int F    = K + ((ROWS > COLS) ? ROWS : COLS) - 1;
  localparam int D    = ((ROWS < COLS) ? ROWS : COLS) - 1 + PE_LAT;
  localparam int CMAX = (F > D) ? F : D;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [CW-1:0] F_LAST = CW'(F - 1);
  localparam logic [CW-1:0] D_LAST = (D > 0) ? CW'(D - 1) : '0;

  if (ROWS < 1 || COLS < 1 || K < 1) begin : g_bad_dims
    $error("systolic_skew_feeder: ROWS, COLS and K must all be >= 1");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_FEED,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [W*ROWS*K-1:0]    a_q, a_d;
  logic [W*K*COLS-1:0]    b_q, b_d;
  logic                   mode_q, mode_d;
  logic [W*ROWS-1:0]      pe_a_q, pe_a_d;
  logic [W*COLS-1:0]      pe_b_q, pe_b_d;
  logic                   valid_q, valid_d;
  logic                   clr_q, clr_d;
  logic                   hold;
  int                     kt;

  // Element (r,k) of the row-major A image; element (0,0) sits in the MSBs.
  function automatic logic [W-1:0] a_elem(input logic [W*ROWS*K-1:0] m, input int r, input int k);
    a_elem = m[(ROWS*K - 1 - (r*K + k))*W +: W];
  endfunction

  // B[k][c]; in transpose mode the image is Bt (COLS x K), so read Bt element (c,k).
  function automatic logic [W-1:0] b_elem(input logic [W*K*COLS-1:0] m, input logic tr,
                                          input int k, input int c);
    int idx;
    idx    = tr ? (c*K + k) : (k*COLS + c);
    b_elem = m[(K*COLS - 1 - idx)*W +: W];
  endfunction

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      mode_q  <= 1'b0;
      pe_a_q  <= '0;
      pe_b_q  <= '0;
      valid_q <= 1'b0;
      clr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      mode_q  <= mode_d;
      pe_a_q  <= pe_a_d;
      pe_b_q  <= pe_b_d;
      valid_q <= valid_d;
      clr_q   <= clr_d;
    end
  end

  // Edge operands are computed from the next state/count so that the values for
  // index t are already registered during the cycle the FSM sits at t.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    mode_d  = mode_q;
    pe_a_d  = pe_a_q;
    pe_b_d  = pe_b_q;
    valid_d = 1'b0;
    clr_d   = 1'b0;
    hold    = 1'b0;
    kt      = 0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (i_start) begin
          state_d = S_FEED;
          cnt_d   = '0;
          clr_d   = 1'b1;
          a_d     = i_A;
          b_d     = i_B;
          mode_d  = i_mode;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FEED: begin
        if (i_stall) begin
          hold = 1'b1;
        end else if (cnt_q == F_LAST) begin
          cnt_d   = '0;
          state_d = (D == 0) ? S_DONE : S_DRAIN;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DRAIN: begin
        if (i_stall) begin
          hold = 1'b1;
        end else if (cnt_q == D_LAST) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (!hold) begin
      pe_a_d = '0;
      pe_b_d = '0;
      if (state_d == S_FEED) begin
        valid_d = 1'b1;
        for (int unsigned r = 0; r < ROWS; r++) begin
          kt = int'(cnt_d) - int'(r);
          if (kt >= 0 && kt < K) pe_a_d[r*W +: W] = a_elem(a_d, int'(r), kt);
        end
        for (int unsigned c = 0; c < COLS; c++) begin
          kt = int'(cnt_d) - int'(c);
          if (kt >= 0 && kt < K) pe_b_d[c*W +: W] = b_elem(b_d, mode_d, kt, int'(c));
        end
      end
    end
  end

  assign o_pe_a       = pe_a_q;
  assign o_pe_b       = pe_b_q;
  assign o_feed_valid = valid_q;
  assign o_acc_clr    = clr_q;
  assign o_busy       = (state_q == S_FEED) || (state_q == S_DRAIN);
  assign o_done       = (state_q == S_DONE);

endmodule
